// File: rtl/quad_nonce_scheduler_if.sv
// Host-side bundle of the nonce scheduler: work offer channel and golden
// nonce result channel.
//
// Handshake rules for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid and
// its payload stable until that transfer; the consumer may raise or drop
// ready at any time. Here work_ready is permanently high, so a work offer
// is taken on the first edge it is seen. gn_nonce is the FIFO head and is
// meaningful only while gn_valid is high.
interface quad_nonce_scheduler_if;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic         gn_valid;
  logic         gn_ready;
  logic [31:0]  gn_nonce;
  logic         gn_overflow;

  modport master (
    output work_valid, work_midstate, work_data, gn_ready,
    input  work_ready, gn_valid, gn_nonce, gn_overflow
  );

  modport slave (
    input  work_valid, work_midstate, work_data, gn_ready,
    output work_ready, gn_valid, gn_nonce, gn_overflow
  );
endinterface

// File: rtl/quad_nonce_scheduler.sv
// Four-lane double-SHA-256 nonce scheduler: drives the shared cnt/feedback/
// nonce schedule, qualifies lane hits, rebuilds golden nonces and queues
// them in a first-word-fall-through result FIFO.
module quad_nonce_scheduler #(
  parameter int          LOOP_LOG2  = 0,
  parameter int          FIFO_DEPTH = 8,
  // start nonce loaded on each work accept; 0 in normal operation
  parameter logic [29:0] NONCE_INIT = 30'd0
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  quad_nonce_scheduler_if.slave host,
  output logic [255:0]          state_o,
  output logic [95:0]           data_tail_o,
  output logic [29:0]           nonce_o,
  output logic [5:0]            cnt_o,
  output logic                  feedback_o,
  output logic                  running,
  output logic                  exhausted,
  input  logic [3:0]            hit_in,
  output logic [1:0]            fsm_state
);
  localparam int LOOP      = 1 << LOOP_LOG2;
  localparam int GN_OFFSET = (LOOP == 1) ? 131 : (LOOP == 2) ? 66 : ((1 << (7 - LOOP_LOG2)) + 1);
  localparam int BLANK     = GN_OFFSET * LOOP;
  localparam int LOOP_M1   = LOOP - 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  LOOP_MASK = LOOP_M1[5:0];
  localparam logic [7:0]  BLANK_LD  = BLANK[7:0];
  localparam logic [29:0] GN_OFF30  = GN_OFFSET[29:0];
  localparam logic [AW:0] DEPTH_C   = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t      state, state_next;
  logic        accept;
  logic [5:0]  cnt_next;
  logic        feedback_next;
  logic        exhaust_now;
  logic [7:0]  blank_cnt;
  logic [7:0]  drain_cnt;
  logic        feedback_d1;
  logic [3:0]  q;
  logic [29:0] snap;
  logic [3:0]  pending;
  logic [31:0] pend_nonce [4];
  logic [3:0]  drain_sel;
  logic        found;
  logic        push;
  logic [31:0] push_data;
  logic        pop;
  logic        can_push;
  logic        hit_lost;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign host.work_ready = 1'b1;
  assign accept          = host.work_valid;

  // schedule lookahead shared by the FSM and the lane counters
  always_comb begin
    cnt_next      = (LOOP == 1) ? 6'd0 : ((cnt_o + 6'd1) & LOOP_MASK);
    feedback_next = (LOOP != 1) && (cnt_next != 6'd0);
    exhaust_now   = (state == S_RUN) && (nonce_o == '1) && !feedback_next && !accept;
  end

  // FSM state register
  always_ff @(posedge hash_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next state: new work always restarts RUN, even mid-drain
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (accept) state_next = S_RUN;
               else if (exhaust_now) state_next = S_DRAIN;
      S_DRAIN: if (accept) state_next = S_RUN;
               else if (drain_cnt <= 8'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    running   = (state != S_IDLE);
    fsm_state = state;
  end

  // work latch, lane schedule, blanking and drain counters
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_o     <= '0;
      data_tail_o <= '0;
      nonce_o     <= '0;
      cnt_o       <= '0;
      feedback_o  <= 1'b0;
      feedback_d1 <= 1'b1;
      exhausted   <= 1'b0;
      blank_cnt   <= '0;
      drain_cnt   <= '0;
    end else begin
      feedback_d1 <= feedback_o;
      exhausted   <= exhaust_now;
      if (accept) begin
        state_o     <= host.work_midstate;
        data_tail_o <= host.work_data;
        nonce_o     <= NONCE_INIT;
        cnt_o       <= '0;
        feedback_o  <= 1'b0;
        blank_cnt   <= BLANK_LD;
      end else begin
        if (running) begin
          cnt_o      <= cnt_next;
          feedback_o <= feedback_next;
          if (!feedback_next) nonce_o <= nonce_o + 30'd1;
        end
        if (blank_cnt != 8'd0) blank_cnt <= blank_cnt - 8'd1;
      end
      if (exhaust_now) drain_cnt <= BLANK_LD;
      else if (state == S_DRAIN && drain_cnt != 8'd0) drain_cnt <= drain_cnt - 8'd1;
    end
  end

  // hit qualification and selection of the pending entry to push
  always_comb begin
    pop      = host.gn_valid && host.gn_ready;
    can_push = (count != DEPTH_C) || pop;
    snap     = nonce_o - GN_OFF30;
    q        = hit_in & {4{!feedback_d1 && running && (blank_cnt == 8'd0)}};
    drain_sel = '0;
    found     = 1'b0;
    push_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i] && !found && can_push) begin
        drain_sel[i] = 1'b1;
        found        = 1'b1;
        push_data    = pend_nonce[i];
      end
    end
    push     = found;
    hit_lost = |(q & pending & ~drain_sel);
  end

  // per-lane pending slots and the sticky overflow flag
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      pending          <= '0;
      host.gn_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) pend_nonce[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q[i] && !(pending[i] && !drain_sel[i])) begin
          pending[i]    <= 1'b1;
          pend_nonce[i] <= {2'(i), snap};
        end else if (drain_sel[i]) begin
          pending[i] <= 1'b0;
        end
      end
      // a loss in the accept cycle still counts as a loss
      if (hit_lost)    host.gn_overflow <= 1'b1;
      else if (accept) host.gn_overflow <= 1'b0;
    end
  end

  // result FIFO pointers and occupancy
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // result FIFO storage; contents are don't-care while empty
  always_ff @(posedge hash_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign host.gn_valid = (count != '0);
  assign host.gn_nonce = (count == '0) ? 32'd0 : mem[rd_ptr];
endmodule

// File: tb/tb_quad_nonce_scheduler.sv
// Bench for quad_nonce_scheduler: a LOOP=1 instance under scoreboard
// checking against a cycle-count reference model, and a LOOP=4 instance
// started near the top of the nonce space for schedule and exhaustion.
module tb_quad_nonce_scheduler;
  // clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_nonce_scheduler_if h0 ();
  quad_nonce_scheduler_if h1 ();

  logic [255:0] st0, st1;
  logic [95:0]  dt0, dt1;
  logic [29:0]  n0, n1;
  logic [5:0]   c0, c1;
  logic         fb0, fb1, run0, run1, ex0, ex1;
  logic [3:0]   hit0, hit1;
  logic [1:0]   fsm0, fsm1;

  localparam logic [29:0] N1_INIT = 30'h3FFF_FFF8;

  quad_nonce_scheduler #(.LOOP_LOG2(0), .FIFO_DEPTH(8)) dut0 (
    .hash_clk(clk), .reset(rst), .host(h0), .state_o(st0), .data_tail_o(dt0),
    .nonce_o(n0), .cnt_o(c0), .feedback_o(fb0), .running(run0), .exhausted(ex0),
    .hit_in(hit0), .fsm_state(fsm0));

  quad_nonce_scheduler #(.LOOP_LOG2(2), .FIFO_DEPTH(8), .NONCE_INIT(N1_INIT)) dut1 (
    .hash_clk(clk), .reset(rst), .host(h1), .state_o(st1), .data_tail_o(dt1),
    .nonce_o(n1), .cnt_o(c1), .feedback_o(fb1), .running(run1), .exhausted(ex1),
    .hit_in(hit1), .fsm_state(fsm1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model of instance 0 (LOOP=1, offset 131, depth 8)
  // nonce_o equals the number of cycles since the last accept; hits count
  // only from cycle 131 on; each lane holds one waiting entry; the FIFO is
  // tracked by occupancy while its contents go to exp_q in push order
  logic [31:0] exp_q[$];
  bit          m_run = 0;
  int unsigned m_k = 0;
  bit          m_pend[4];
  logic [31:0] m_pval[4];
  int          m_occ = 0;
  bit          m_ovf = 0;
  bit          mon_en = 0;

  task automatic model_step();
    bit pop, can_push;
    if (rst) begin
      m_run = 0; m_k = 0; m_occ = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      exp_q.delete();
      return;
    end
    pop      = (m_occ > 0) && h0.gn_ready;
    can_push = (m_occ < 8) || pop;
    m_occ    = m_occ - (pop ? 1 : 0);
    if (can_push) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          exp_q.push_back(m_pval[i]);
          m_pend[i] = 0;
          m_occ++;
          break;
        end
      end
    end
    if (h0.work_valid) m_ovf = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_run && m_k >= 131 && hit0[i]) begin
        if (m_pend[i]) m_ovf = 1;
        else begin
          m_pend[i] = 1;
          m_pval[i] = {2'(i), 30'(m_k - 131)};
        end
      end
    end
    if (h0.work_valid) begin m_run = 1; m_k = 0; end
    else if (m_run) m_k++;
  endtask

  // driver: one clock, model advanced on the same edge as the DUT
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // monitor / scoreboard for instance 0
  always @(negedge clk) begin
    if (mon_en) begin
      if (h0.gn_valid && h0.gn_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL gn_pop: got 0x%0h, expected no entry (queue empty) at %0t", h0.gn_nonce, $time);
        end else begin
          chk("gn_nonce", h0.gn_nonce, exp_q.pop_front());
        end
      end
      chk("gn_valid", h0.gn_valid, m_occ > 0);
      chk("gn_overflow", h0.gn_overflow, m_ovf);
      chk("running0", run0, m_run);
      chk("nonce0", n0, m_k[29:0]);
      chk("work_ready0", h0.work_ready, 1'b1);
      chk("exhausted0", ex0, 1'b0);
      chk("cnt0", c0, 6'd0);
      chk("feedback0", fb0, 1'b0);
    end
  end

  initial begin
    logic [255:0] mid;
    logic [95:0]  tail;
    logic [31:0]  exp1;
    int           ex_cnt;
    int           jj;
    int           guard;

    rst = 1'b1;
    h0.work_valid = 0; h0.work_midstate = '0; h0.work_data = '0; h0.gn_ready = 0;
    h1.work_valid = 0; h1.work_midstate = '0; h1.work_data = '0; h1.gn_ready = 0;
    hit0 = '0; hit1 = '0;
    repeat (3) step();

    // reset values, with a work offer held during reset (reset wins)
    h0.work_valid = 1;
    step();
    h0.work_valid = 0;
    @(negedge clk);
    chk("rst work_ready", h0.work_ready, 1'b1);
    chk("rst running", run0, 1'b0);
    chk("rst exhausted", ex0, 1'b0);
    chk("rst cnt", c0, 6'd0);
    chk("rst feedback", fb0, 1'b0);
    chk("rst nonce", n0, 30'd0);
    chk("rst state_o", st0, 256'd0);
    chk("rst data_tail", dt0, 96'd0);
    chk("rst gn_valid", h0.gn_valid, 1'b0);
    chk("rst gn_nonce", h0.gn_nonce, 32'd0);
    chk("rst gn_overflow", h0.gn_overflow, 1'b0);
    chk("rst fsm", fsm0, 2'd0);
    chk("rst fsm1", fsm1, 2'd0);
    chk("rst running1", run1, 1'b0);
    rst = 1'b0;
    mon_en = 1;

    // accept work, check latched payload
    for (int i = 0; i < 8; i++) mid[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) tail[i*32 +: 32] = $urandom;
    h0.work_valid = 1; h0.work_midstate = mid; h0.work_data = tail;
    step();
    h0.work_valid = 0; h0.work_midstate = '0; h0.work_data = '0;
    chk("state_o latch", st0, mid);
    chk("data_tail latch", dt0, tail);
    chk("fsm run", fsm0, 2'd1);

    // lane 2 hit at nonce 1000 -> 0x80000365
    guard = 0;
    while (m_k != 1000 && guard < 2000) begin step(); guard++; end
    h0.gn_ready = 1;
    hit0 = 4'b0100;
    step();
    hit0 = 4'b0000;
    step();
    chk("hit1000 valid", h0.gn_valid, 1'b1);
    chk("hit1000 nonce", h0.gn_nonce, 32'h8000_0365);
    repeat (3) step();

    // all four lanes at once, drained in lane order
    hit0 = 4'b1111;
    step();
    hit0 = 4'b0000;
    repeat (8) step();

    // overflow: 13 lane-0 hits with the consumer stalled
    h0.gn_ready = 0;
    repeat (13) begin hit0 = 4'b0001; step(); end
    hit0 = 4'b0000;
    repeat (3) step();
    chk("ovf set", h0.gn_overflow, 1'b1);
    chk("ovf fifo valid", h0.gn_valid, 1'b1);
    h0.work_valid = 1;
    step();
    h0.work_valid = 0;
    chk("ovf cleared", h0.gn_overflow, 1'b0);
    chk("fifo retained", h0.gn_valid, 1'b1);

    // blanking window after accept, then the first live hit
    h0.gn_ready = 1;
    repeat (131) begin hit0 = 4'($urandom_range(1, 15)); step(); end
    hit0 = 4'b0001;
    step();
    hit0 = 4'b0000;
    repeat (12) step();
    chk("blank no ovf", h0.gn_overflow, 1'b0);

    // randomized traffic with a mid-run reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      hit0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (((cyc / 250) % 2) == 0) h0.gn_ready = ($urandom_range(0, 3) == 0);
      else                        h0.gn_ready = ($urandom_range(0, 9) != 0);
      h0.work_valid = ($urandom_range(0, 399) == 0);
      rst = (cyc == 1500);
      if (cyc == 1500 || cyc == 1501) h0.work_valid = 1;
      step();
    end
    rst = 0; h0.work_valid = 0; hit0 = '0; h0.gn_ready = 1;
    repeat (30) step();
    chk("exp_q drained", exp_q.size(), 0);

    // LOOP=4 instance: schedule, blanking, feedback gating, exhaustion
    h1.work_valid = 1;
    step();
    h1.work_valid = 0;
    ex_cnt = 0;
    for (int j = 0; j < 200; j++) begin
      jj = (j < 164) ? j : 164;
      chk("l4 cnt", c1, 6'(jj % 4));
      chk("l4 feedback", fb1, (jj % 4) != 0);
      chk("l4 nonce", n1, (jj < 32) ? 30'(N1_INIT + 30'(jj / 4)) : 30'((jj - 32) / 4));
      chk("l4 running", run1, j < 164);
      chk("l4 exhausted", ex1, j == 32);
      chk("l4 fsm", fsm1, (j < 32) ? 2'd1 : (j < 164) ? 2'd2 : 2'd0);
      chk("l4 work_ready", h1.work_ready, 1'b1);
      if (ex1) ex_cnt++;
      if (j == 133)                 hit1 = 4'b0010;
      else if (j >= 134 && j <= 136) hit1 = 4'b0001;
      else                          hit1 = 4'b0000;
      step();
    end
    hit1 = '0;
    chk("l4 exhaust pulses", ex_cnt, 1);
    exp1 = {2'd1, 30'(30'((133 - 32) / 4) - 30'd33)};
    chk("l4 hit valid", h1.gn_valid, 1'b1);
    chk("l4 hit nonce", h1.gn_nonce, exp1);
    h1.gn_ready = 1;
    step();
    h1.gn_ready = 0;
    chk("l4 gated hits dropped", h1.gn_valid, 1'b0);
    chk("l4 no ovf", h1.gn_overflow, 1'b0);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quad_nonce_scheduler.md
Name: quad_nonce_scheduler

Overview:
- Sequences the four-lane double-SHA-256 hasher array: accepts work (midstate plus 96-bit data tail) from the host side and drives the shared cnt/feedback/nonce schedule to all lanes.
- Qualifies each lane's hit flag and reconstructs the 32-bit golden nonce as {lane, 30-bit nonce}.
- Serialises simultaneous multi-lane hits into a result FIFO with a valid/ready handshake, so no hit is lost to priority encoding.
- Sits between the virtual-wire/host interface and the sha256_transform lane pairs.

Parameters:
- LOOP_LOG2, 0, unroll factor of the lanes, valid range 0..5; LOOP = 1<<LOOP_LOG2.
- GN_OFFSET, derived, nonce lag from lane input to hit: 131 if LOOP==1, 66 if LOOP==2, else (1<<(7-LOOP_LOG2))+1.
- FIFO_DEPTH, 8, result FIFO entries, power of two, minimum 4.

Ports:
- hash_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- work_valid  in  1  new work offered.
- work_ready  out  1  work can be accepted.
- work_midstate  in  256  midstate for the offered work.
- work_data  in  96  data tail for the offered work.
- state_o  out  256  midstate to the lanes.
- data_tail_o  out  96  data tail to the lanes.
- nonce_o  out  30  lane nonce; lane i uses {i[1:0], nonce_o}.
- cnt_o  out  6  round counter to the lanes.
- feedback_o  out  1  feedback select to the lanes.
- running  out  1  high in RUN or DRAIN.
- exhausted  out  1  one-cycle pulse when the nonce space is finished.
- hit_in  in  4  raw per-lane comparators, true when hash[255:224]==0.
- gn_valid  out  1  result available.
- gn_ready  in  1  result consumed.
- gn_nonce  out  32  golden nonce at the FIFO head.
- gn_overflow  out  1  sticky: at least one hit was lost.

Behaviour:
- Reset values: state IDLE; work_ready=1; running=0; exhausted=0; cnt_o=0; feedback_o=0; nonce_o=0; state_o=0; data_tail_o=0; FIFO empty; gn_valid=0; gn_nonce=0; gn_overflow=0; pending mask=0; feedback_d1=1.
- Reset mid-operation returns everything to these values on the next edge, including discarding FIFO contents.
- Work handshake:
  - Work is accepted on work_valid&&work_ready. work_ready=1 in all states.
  - On accept: latch state_o and data_tail_o, nonce_o<=0, cnt_o<=0, feedback_o<=0, clear gn_overflow, load the blank counter with GN_OFFSET*LOOP, enter RUN.
  - Previously queued FIFO entries are kept.
- Schedule (RUN and DRAIN):
  - cnt_next = (LOOP==1) ? 0 : (cnt_o+1) mod LOOP.
  - feedback_next = (LOOP!=1) && (cnt_next!=0).
  - nonce_o increments by 1, mod 2^30, on edges where feedback_next==0.
  - In IDLE all three hold.
- Nonce exhaustion:
  - In RUN, when nonce_o==2^30-1 and it is about to increment, pulse exhausted, enter DRAIN, load the drain counter with GN_OFFSET*LOOP.
  - In DRAIN the schedule keeps running. The counter decrements each cycle; at 0 go to IDLE.
  - Work accepted in DRAIN restarts RUN immediately; the drain is abandoned.
- Hit qualification:
  - feedback_d1 <= feedback_o.
  - q[i] = hit_in[i] && !feedback_d1 && (state!=IDLE) && (blank counter==0).
  - The blank counter decrements to 0 each cycle. While it is nonzero, hits are discarded as stale (previous work) without setting overflow.
- Nonce reconstruction:
  - For each q[i], the 30-bit snapshot is (nonce_o − GN_OFFSET) mod 2^30, computed with a 30-bit subtraction. The lane index is never borrowed into.
  - The entry is {i[1:0], snapshot}.
- Pending stage:
  - Each qualified hit sets pending[i] and stores the entry in pend_nonce[i].
  - If pending[i] is already set and not being drained that cycle, the new hit is dropped and gn_overflow<=1.
  - Each cycle, the lowest-index set pending bit is pushed to the FIFO if the FIFO is not full, and that bit is cleared.
  - If the FIFO is full, the push stalls; pending bits hold.
- Result FIFO:
  - First-word-fall-through: gn_nonce is the head and gn_valid = !empty.
  - A pop occurs on gn_valid&&gn_ready.
  - A simultaneous push and pop when full is allowed, with no loss.
  - Count and pointers wrap mod FIFO_DEPTH.
- Simultaneous events:
  - Work accept and reset in the same cycle: reset wins.
  - A hit qualifying in the same cycle that its pending bit drains is accepted; no overflow.

Test Plan:
- Reset, then one work item with LOOP_LOG2=0; force hit_in=4'b0100 at nonce_o=1000 → one entry gn_nonce=0x80000365 (lane 2, 1000−131=869), gn_overflow=0.
- LOOP_LOG2=2: check cnt_o sequence 0,1,2,3,0; feedback_o=0 only when cnt_o==0; nonce_o advances once per 4 cycles; a hit asserted while feedback_d1=1 is ignored.
- hit_in=4'b1111 in one qualified cycle with gn_ready=1 → four entries on consecutive pops in lane order 0,1,2,3, all sharing the same low-30-bit snapshot.
- Preload nonce_o=2^30−2, LOOP_LOG2=0: exhausted pulses once at the wrap; running stays high for 131 more cycles, then work_ready remains 1 and state=IDLE.
- gn_ready=0 with FIFO_DEPTH=8 and 13 lane-0 hits on successive cycles → FIFO holds 8, one pending entry holds, gn_overflow=1; the next work accept clears gn_overflow and retains the 8 entries.
- New work accepted at an arbitrary point in RUN, then hits driven for the next GN_OFFSET*LOOP cycles → no FIFO pushes and no overflow; a hit one cycle later is queued normally.
